// File: rtl/spi_sram_master.sv
// SPI mode-0 initiator for a 23LC512-class serial SRAM.
// Turns one host request into a single-byte SPI transaction:
// {cmd[7:0], addr[15:0], data[7:0]}, shifted MSB first.
// Ports:
//   clk_i, rst_i               system clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (transfer when both high)
//   req_write_i                1 = WRITE (0x02), 0 = READ (0x03)
//   req_addr_i, req_wdata_i    SRAM byte address and write byte
//   resp_valid_o               one-cycle completion pulse
//   resp_rdata_o               read byte (0x00 after writes), held until next response
//   sck_o, cs_n_o, mosi_o      SPI outputs (sck idles low, cs_n idles high)
//   miso_i                     SPI input from the SRAM
module spi_sram_master #(
  parameter int unsigned ClkDiv = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        resp_valid_o,
  output logic [7:0]  resp_rdata_o,
  output logic        sck_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic              last_q, last_d;   // bit 31 has fallen; next low phase ends the frame
  logic [31:0]       shreg_q, shreg_d;
  logic [7:0]        rx_q, rx_d;
  logic              is_read_q, is_read_d;
  logic              sck_q, sck_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              div_last;
  logic [31:0]       frame;

  assign div_last = (div_q == DivW'(ClkDiv - 1));

  always_comb begin
    frame        = {(req_write_i ? 8'h02 : 8'h03), req_addr_i,
                    (req_write_i ? req_wdata_i : 8'h00)};
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    last_d       = last_q;
    shreg_d      = shreg_q;
    rx_d         = rx_q;
    is_read_d    = is_read_q;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (req_valid_i) begin
          shreg_d   = frame;
          mosi_d    = frame[31];
          cs_n_d    = 1'b0;
          bit_d     = '0;
          last_d    = 1'b0;
          is_read_d = ~req_write_i;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        if (div_last) begin
          div_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], miso_i};
          state_d = StShiftHi;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StShiftHi: begin
        if (div_last) begin
          div_d   = '0;
          sck_d   = 1'b0;
          state_d = StShiftLo;
          if (bit_q == 5'd31) begin
            mosi_d = 1'b0;
            last_d = 1'b1;
          end else begin
            // Next bit goes out on the falling edge, a full low phase before its rise.
            mosi_d  = shreg_q[30];
            shreg_d = {shreg_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StShiftLo: begin
        if (div_last) begin
          div_d = '0;
          if (last_q) begin
            cs_n_d       = 1'b1;
            resp_valid_d = 1'b1;
            rdata_d      = is_read_q ? rx_q : 8'h00;
            state_d      = StGap;
          end else begin
            // miso still holds the value driven before this rise.
            sck_d   = 1'b1;
            rx_d    = {rx_q[6:0], miso_i};
            state_d = StShiftHi;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StGap: begin
        if (div_last) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      last_q       <= 1'b0;
      shreg_q      <= '0;
      rx_q         <= '0;
      is_read_q    <= 1'b0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      last_q       <= last_d;
      shreg_q      <= shreg_d;
      rx_q         <= rx_d;
      is_read_q    <= is_read_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign sck_o        = sck_q;
  assign cs_n_o       = cs_n_q;
  assign mosi_o       = mosi_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench for spi_sram_master: two instances (ClkDiv 2 and 1) share one behavioural
// serial-SRAM model through a selector; expected data comes from a separate
// reference memory and expected timing from the frame arithmetic.
module tb_spi_sram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [1:0]  req_ready, resp_valid, sck, cs_n, mosi;
  logic [7:0]  rdata0, rdata1;
  logic        miso = 1'b0;
  logic        sel = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_sram_master #(.ClkDiv(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(rdata0), .sck_o(sck[0]), .cs_n_o(cs_n[0]),
    .mosi_o(mosi[0]), .miso_i(miso)
  );

  spi_sram_master #(.ClkDiv(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(rdata1), .sck_o(sck[1]), .cs_n_o(cs_n[1]),
    .mosi_o(mosi[1]), .miso_i(miso)
  );

  // ---------------- serial SRAM model on the selected instance ----------------
  logic        m_sck, m_cs_n, m_mosi;
  assign m_sck  = sck[sel];
  assign m_cs_n = cs_n[sel];
  assign m_mosi = mosi[sel];

  logic [7:0]  sram    [65536];
  logic [7:0]  ref_mem [65536];
  logic [31:0] fr = '0;
  int          nbits = 0;
  logic [7:0]  rd_byte = '0;
  logic [31:0] last_frame = '0;
  int          last_bits = 0;

  always @(negedge m_cs_n) begin
    nbits = 0;
    fr    = '0;
  end

  always @(posedge m_sck) begin
    if (m_cs_n === 1'b0) begin
      fr = {fr[30:0], m_mosi};
      nbits++;
    end
  end

  // After the 24th rise a read command drives its data byte, one bit per falling edge.
  always @(negedge m_sck) begin
    if (m_cs_n === 1'b0) begin
      if (nbits == 24) rd_byte = (fr[23:16] == 8'h03) ? sram[fr[15:0]] : 8'h00;
      if (nbits >= 24 && nbits < 32) miso = rd_byte[31 - nbits];
      else miso = 1'b0;
    end
  end

  always @(posedge m_cs_n) begin
    last_frame = fr;
    last_bits  = nbits;
    if (nbits == 32 && fr[31:24] == 8'h02) sram[fr[23:8]] = fr[7:0];
    miso = 1'b0;
  end

  // Next request for the back-to-back mode.
  logic        nx_wr;
  logic [15:0] nx_a;
  logic [7:0]  nx_wd;

  // One transaction on instance d. mode: 0 plain, 1 disturb inputs mid-frame,
  // 2 leave req_valid high with nx_* presented as the next request.
  // Called and returning at a negative clock edge.
  task automatic do_txn(input int d, input bit wr, input logic [15:0] a, input logic [7:0] wd,
                        input int mode);
    int          cd;
    int          rises, rise_bad, resp_n, ready_n, pulses;
    logic [7:0]  exp_rd, rd_at_resp, rd_now;
    logic [31:0] exp_fr;
    logic        prev_sck;
    cd     = (d == 0) ? 2 : 1;
    sel    = d[0];
    exp_fr = {(wr ? 8'h02 : 8'h03), a, (wr ? wd : 8'h00)};
    exp_rd = wr ? 8'h00 : ref_mem[a];
    if (wr) ref_mem[a] = wd;

    total++;
    if (req_ready[d] !== 1'b1) begin
      bad++; $display("FAIL ready_before d=%0d: got %b want 1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    if (mode == 2) begin
      req_write = nx_wr; req_addr = nx_a; req_wdata = nx_wd;
    end else begin
      req_valid[d] = 1'b0;
    end

    rises = 0; rise_bad = 0; resp_n = -1; ready_n = -1; pulses = 0; prev_sck = 1'b0;
    rd_at_resp = 8'h00;
    for (int n = 0; n < 70 * cd + 5 && ready_n < 0; n++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (n >= 20 && n < 60) begin
          req_valid[d] = n[0]; req_addr = 16'h0300; req_wdata = 8'hFF; req_write = ~wr;
        end else if (n == 60) begin
          req_valid[d] = 1'b0;
        end
      end
      if (sck[d] === 1'b1 && prev_sck === 1'b0) begin
        if (n != (1 + 2 * rises) * cd) rise_bad++;
        rises++;
      end
      prev_sck = sck[d];
      rd_now = (d == 0) ? rdata0 : rdata1;
      if (resp_valid[d] === 1'b1) begin
        pulses++;
        if (resp_n < 0) begin resp_n = n; rd_at_resp = rd_now; end
      end
      if (req_ready[d] === 1'b1) ready_n = n;
    end

    total++;
    if (rises != 32 || rise_bad != 0) begin
      bad++; $display("FAIL sck_rises d=%0d: got %0d rises (%0d mistimed) want 32 on time",
                      d, rises, rise_bad);
    end
    total++;
    if (resp_n != 65 * cd || pulses != 1) begin
      bad++; $display("FAIL resp_timing d=%0d: got cycle %0d pulses %0d want cycle %0d pulses 1",
                      d, resp_n, pulses, 65 * cd);
    end
    total++;
    if (rd_at_resp !== exp_rd) begin
      bad++; $display("FAIL rdata d=%0d a=%h: got %h want %h", d, a, rd_at_resp, exp_rd);
    end
    total++;
    if (ready_n != 66 * cd) begin
      bad++; $display("FAIL ready_after d=%0d: got cycle %0d want %0d", d, ready_n, 66 * cd);
    end
    total++;
    if (last_frame !== exp_fr || last_bits != 32) begin
      bad++; $display("FAIL frame d=%0d: got %h (%0d bits) want %h (32 bits)",
                      d, last_frame, last_bits, exp_fr);
    end
    total++;
    if (sram[a] !== ref_mem[a]) begin
      bad++; $display("FAIL sram_content a=%h: got %h want %h", a, sram[a], ref_mem[a]);
    end
    total++;
    if (cs_n[d] !== 1'b1 || sck[d] !== 1'b0 || mosi[d] !== 1'b0) begin
      bad++; $display("FAIL idle_pins d=%0d: got cs_n=%b sck=%b mosi=%b want 1 0 0",
                      d, cs_n[d], sck[d], mosi[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 2'b11 || resp_valid !== 2'b00 || rdata0 !== 8'h00 || rdata1 !== 8'h00 ||
        sck !== 2'b00 || cs_n !== 2'b11 || mosi !== 2'b00) begin
      bad++; $display("FAIL reset_values: got ready=%b rv=%b rd=%h/%h sck=%b cs_n=%b mosi=%b",
                      req_ready, resp_valid, rdata0, rdata1, sck, cs_n, mosi);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    do_txn(0, 1'b1, 16'h0012, 8'hA5, 0);
    do_txn(0, 1'b0, 16'h0012, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    nx_wr = 1'b1; nx_a = 16'h0002; nx_wd = 8'h22;
    do_txn(0, 1'b1, 16'h0001, 8'h11, 2);
    // req_valid is still high: the second write is taken on the first ready cycle.
    nx_wr = 1'b0; nx_a = 16'h0001; nx_wd = 8'h00;
    do_txn(0, 1'b1, 16'h0002, 8'h22, 2);
    nx_wr = 1'b0; nx_a = 16'h0002; nx_wd = 8'h00;
    do_txn(0, 1'b0, 16'h0001, 8'h00, 2);
    do_txn(0, 1'b0, 16'h0002, 8'h00, 0);
  endtask

  task automatic test_disturb();
    do_txn(0, 1'b0, 16'h0012, 8'h00, 1);
  endtask

  task automatic test_reset_abort();
    int seen;
    sel = 1'b0;
    req_valid[0] = 1'b1; req_write = 1'b0; req_addr = 16'h0012; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    // Bit 10 rises at cycle 42 with ClkDiv 2; reset is applied while it is high.
    for (int n = 0; n < 43; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0 || req_ready[0] !== 1'b1 || mosi[0] !== 1'b0 ||
        resp_valid[0] !== 1'b0 || rdata0 !== 8'h00) begin
      bad++; $display("FAIL abort_pins: got cs_n=%b sck=%b ready=%b mosi=%b rv=%b rd=%h",
                      cs_n[0], sck[0], req_ready[0], mosi[0], resp_valid[0], rdata0);
    end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (resp_valid[0] === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || last_bits != 11) begin
      bad++; $display("FAIL abort_no_resp: got %0d pulses, %0d bits seen want 0 pulses 11 bits",
                      seen, last_bits);
    end
    do_txn(0, 1'b0, 16'h0012, 8'h00, 0);
  endtask

  task automatic test_clkdiv1();
    do_txn(1, 1'b1, 16'h03FF, 8'h3C, 0);
    do_txn(1, 1'b0, 16'h03FF, 8'h00, 0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {14'h2A0, 2'($urandom)};
      do_txn(i % 2, 1'($urandom), a, 8'($urandom), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_disturb();
    test_reset_abort();
    test_clkdiv1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
